// File: rtl/lcd_rx_pkg.sv
// Shared types and constants for the parallel-RGB LCD receive path.
// Holds the capture FSM states, default frame geometry and the CRC-16-CCITT step.
package lcd_rx_pkg;

    localparam int H_ACTIVE_DEF = 480;
    localparam int V_ACTIVE_DEF = 272;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LINE = 2'd1,
        ACTIVE    = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    // One pixel per call, MSB first, so R[7] enters the CRC before B[0].
    function automatic logic [15:0] crc16_step24(input logic [15:0] crc_in,
                                                 input logic [23:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 23; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/pixel_crc16.sv
// Running CRC-16-CCITT over captured pixels, one 24-bit R,G,B word per cycle.
// Restarts from CRC_INIT on clear; advances only on cycles where en is high.
module pixel_crc16
    import lcd_rx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic [23:0] data,
    output logic [15:0] crc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     crc <= CRC_INIT;
        else if (clear) crc <= CRC_INIT;
        else if (en)    crc <= crc16_step24(crc, data);
    end

endmodule

// File: rtl/lcd_rgb_capture.sv
// Receive side of the DE-mode parallel-RGB LCD bus: rebuilds x/y, framing and errors.
// Define LCD_CAPTURE_CRC_EN to add a per-frame CRC-16 on frame_crc (else it reads 0).
module lcd_rgb_capture
    import lcd_rx_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lcd_hsync_n,
    input  logic        lcd_vsync_n,
    input  logic        lcd_de,
    input  logic [7:0]  lcd_r,
    input  logic [7:0]  lcd_g,
    input  logic [7:0]  lcd_b,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic        frame_start,
    output logic        frame_done,
    output logic        line_len_err,
    output logic        frame_len_err,
    output logic [15:0] frame_crc
);

    localparam logic [1:0] S_IDLE      = IDLE;
    localparam logic [1:0] S_WAIT_LINE = WAIT_LINE;
    localparam logic [1:0] S_ACTIVE    = ACTIVE;

    localparam logic [9:0] X_MAX  = 10'(H_ACTIVE);
    localparam logic [8:0] Y_MAX  = 9'(V_ACTIVE);
    localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);

    // HSync carries no information the DE edges do not already give us.
    logic unused_hsync;
    assign unused_hsync = lcd_hsync_n;

    logic   vs_q, vs_d, de_q;
    pixel_t px_q;

    // Both vsync history bits reset to the asserted level so releasing reset
    // can never look like a fresh frame sync.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            vs_q <= 1'b0;
            vs_d <= 1'b0;
            de_q <= 1'b0;
            px_q <= '0;
        end else begin
            vs_q <= lcd_vsync_n;
            vs_d <= vs_q;
            de_q <= lcd_de;
            px_q <= '{r: lcd_r, g: lcd_g, b: lcd_b};
        end
    end

    logic vs_assert;
    assign vs_assert = vs_d & ~vs_q;

    logic [1:0] state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic       done_seen_q, done_seen_d;
    logic       ovf_q, ovf_d;
    logic       emit, start, done, l_err, f_err, crc_clear;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        done_seen_d = done_seen_q;
        ovf_d       = ovf_q;
        emit        = 1'b0;
        start       = 1'b0;
        done        = 1'b0;
        l_err       = 1'b0;
        f_err       = 1'b0;
        crc_clear   = 1'b0;

        if (vs_assert) begin
            // VSync outranks DE: any pixel on this cycle is dropped.
            f_err       = (state_q != S_IDLE) && (y_q < Y_MAX) && !done_seen_q;
            state_d     = S_WAIT_LINE;
            x_d         = '0;
            y_d         = '0;
            done_seen_d = 1'b0;
            ovf_d       = 1'b0;
            crc_clear   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_WAIT_LINE: begin
                    if (de_q) begin
                        if (y_q == Y_MAX) begin
                            f_err   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_ACTIVE;
                            emit    = 1'b1;
                            start   = (y_q == '0);
                            x_d     = 10'd1;
                            ovf_d   = 1'b0;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (de_q) begin
                        if (x_q < X_MAX) begin
                            emit = 1'b1;
                            x_d  = x_q + 10'd1;
                        end else if (!ovf_q) begin
                            l_err = 1'b1;
                            ovf_d = 1'b1;
                        end
                    end else begin
                        if (x_q != X_MAX) begin
                            l_err = 1'b1;
                        end else if (y_q == Y_LAST) begin
                            done        = 1'b1;
                            done_seen_d = 1'b1;
                        end
                        if (y_q < Y_MAX) y_d = y_q + 9'd1;
                        x_d     = '0;
                        state_d = S_WAIT_LINE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            done_seen_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            done_seen_q <= done_seen_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_valid     <= 1'b0;
            pix_x         <= '0;
            pix_y         <= '0;
            pix_r         <= '0;
            pix_g         <= '0;
            pix_b         <= '0;
            frame_start   <= 1'b0;
            frame_done    <= 1'b0;
            line_len_err  <= 1'b0;
            frame_len_err <= 1'b0;
        end else begin
            pix_valid     <= emit;
            frame_start   <= start;
            frame_done    <= done;
            line_len_err  <= l_err;
            frame_len_err <= f_err;
            if (emit) begin
                pix_x <= x_q;
                pix_y <= y_q;
                pix_r <= px_q.r;
                pix_g <= px_q.g;
                pix_b <= px_q.b;
            end
        end
    end

`ifdef LCD_CAPTURE_CRC_EN
    logic [15:0] crc_run;

    pixel_crc16 u_crc (
        .clk   (clk),
        .reset (reset),
        .clear (crc_clear),
        .en    (emit),
        .data  (px_q),
        .crc   (crc_run)
    );

    // The last pixel was folded in on the previous edge, so crc_run is final here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    frame_crc <= '0;
        else if (done) frame_crc <= crc_run;
    end
`else
    logic unused_crc_clear;
    assign unused_crc_clear = crc_clear;
    assign frame_crc        = '0;
`endif

endmodule

// File: tb/tb_lcd_rgb_capture.sv
// Randomised bench for lcd_rgb_capture with a frame/line-level reference model and scoreboard.
// Builds with or without LCD_CAPTURE_CRC_EN; frame_crc expectations follow the macro.
module tb_lcd_rgb_capture;

    localparam int H = 8;
    localparam int V = 4;
`ifdef LCD_CAPTURE_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        lcd_hsync_n, lcd_vsync_n, lcd_de;
    logic [7:0]  lcd_r, lcd_g, lcd_b;
    logic        pix_valid, frame_start, frame_done, line_len_err, frame_len_err;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic [15:0] frame_crc;

    lcd_rgb_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk           (clk),
        .reset         (reset),
        .lcd_hsync_n   (lcd_hsync_n),
        .lcd_vsync_n   (lcd_vsync_n),
        .lcd_de        (lcd_de),
        .lcd_r         (lcd_r),
        .lcd_g         (lcd_g),
        .lcd_b         (lcd_b),
        .pix_valid     (pix_valid),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_r         (pix_r),
        .pix_g         (pix_g),
        .pix_b         (pix_b),
        .frame_start   (frame_start),
        .frame_done    (frame_done),
        .line_len_err  (line_len_err),
        .frame_len_err (frame_len_err),
        .frame_crc     (frame_crc)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    typedef struct {
        int unsigned at;
        bit          valid;
        int          x, y;
        logic [7:0]  r, g, b;
        bit          fstart, fdone, lerr, ferr;
        logic [15:0] crc;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: tracks frame/line progress in counts, not FSM states.
    bit          m_prev_vs = 1'b1;
    bit          m_capt, m_inline, m_flagged, m_done;
    int          m_col, m_row;
    logic [15:0] m_crc = 16'hFFFF;
    logic [15:0] m_frame_crc = 16'h0;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] t;
        t = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) t = t[15] ? ((t << 1) ^ 16'h1021) : (t << 1);
        return t;
    endfunction

    task automatic model_reset();
        m_capt = 0; m_inline = 0; m_flagged = 0; m_done = 0;
        m_col = 0; m_row = 0; m_crc = 16'hFFFF; m_frame_crc = 16'h0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit vs_n, input bit de, input logic [7:0] r, g, b);
        exp_t e;
        e = '{at: cyc + 2, valid: 0, x: 0, y: 0, r: r, g: g, b: b,
              fstart: 0, fdone: 0, lerr: 0, ferr: 0, crc: 16'h0};
        if (m_prev_vs && !vs_n) begin
            e.ferr   = m_capt && !m_done && (m_row < V);
            m_capt   = 1; m_inline = 0; m_row = 0; m_done = 0;
            m_crc    = 16'hFFFF;
        end else if (m_capt) begin
            if (de && !m_inline) begin
                if (m_row == V) begin
                    e.ferr = 1;
                    m_capt = 0;
                end else begin
                    m_inline = 1; m_col = 0; m_flagged = 0;
                end
            end
            if (de && m_inline) begin
                if (m_col < H) begin
                    e.valid  = 1; e.x = m_col; e.y = m_row;
                    e.fstart = (m_col == 0) && (m_row == 0);
                    m_crc    = crc_byte(crc_byte(crc_byte(m_crc, r), g), b);
                    m_col++;
                end else if (!m_flagged) begin
                    e.lerr = 1; m_flagged = 1;
                end
            end else if (!de && m_inline) begin
                m_inline = 0;
                if (m_col != H) e.lerr = 1;
                else if (m_row == V - 1) begin
                    e.fdone = 1; m_done = 1;
                    if (CRC_ON) m_frame_crc = m_crc;
                end
                if (m_row < V) m_row++;
            end
        end
        e.crc     = m_frame_crc;
        m_prev_vs = vs_n;
        if (e.valid || e.fdone || e.lerr || e.ferr) exp_q.push_back(e);
    endtask

    bit model_on = 1'b0;

    task automatic tick(input bit vs_n, input bit hs_n, input bit de, input logic [7:0] r, g, b);
        lcd_vsync_n = vs_n; lcd_hsync_n = hs_n; lcd_de = de;
        lcd_r = r; lcd_g = g; lcd_b = b;
        if (model_on) model_step(vs_n, de, r, g, b);
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_pulse();
        repeat (2) tick(0, 1, 0, 8'h0, 8'h0, 8'h0);
        repeat (2) tick(1, 1, 0, 8'h0, 8'h0, 8'h0);
    endtask

    // mode 0: R=x, G=y, B=0x5A; mode 1: random; mode 2: all zero
    task automatic send_line(input int len, input int row, input int mode);
        logic [7:0] r, g, b;
        tick(1, 0, 0, 8'h0, 8'h0, 8'h0);
        repeat (1 + $urandom_range(0, 2)) tick(1, 1, 0, 8'h0, 8'h0, 8'h0);
        for (int i = 0; i < len; i++) begin
            case (mode)
                0:       begin r = 8'(i); g = 8'(row); b = 8'h5A; end
                1:       begin r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); end
                default: begin r = 8'h0; g = 8'h0; b = 8'h0; end
            endcase
            tick(1, 1, 1, r, g, b);
        end
        tick(1, 1, 0, 8'h0, 8'h0, 8'h0);
    endtask

    task automatic send_frame(input int lens[$], input int mode);
        vsync_pulse();
        foreach (lens[i]) send_line(lens[i], i, mode);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pix_valid"}, 32'(pix_valid), 0);
        check({tag, "_pix_xy"}, {13'h0, pix_x, pix_y}, 0);
        check({tag, "_pix_rgb"}, {8'h0, pix_r, pix_g, pix_b}, 0);
        check({tag, "_flags"}, {28'h0, frame_start, frame_done, line_len_err, frame_len_err}, 0);
        check({tag, "_frame_crc"}, 32'(frame_crc), 0);
    endtask

    // Monitor: pops one expectation per cycle in which the DUT shows any event.
    always @(negedge clk) begin
        if (reset) begin
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                exp_t m;
                m = exp_q.pop_front();
                check("event_cycle_missed", cyc, m.at);
            end
            if (pix_valid || frame_start || frame_done || line_len_err || frame_len_err) begin
                if (exp_q.size() == 0) begin
                    check("outputs_when_none_expected",
                          {27'h0, pix_valid, frame_start, frame_done, line_len_err, frame_len_err}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("event_cycle", cyc, e.at);
                    check("pix_valid", 32'(pix_valid), 32'(e.valid));
                    if (e.valid) begin
                        check("pix_x", 32'(pix_x), 32'(e.x));
                        check("pix_y", 32'(pix_y), 32'(e.y));
                        check("pix_rgb", {8'h0, pix_r, pix_g, pix_b}, {8'h0, e.r, e.g, e.b});
                    end
                    check("frame_start", 32'(frame_start), 32'(e.fstart));
                    check("frame_done", 32'(frame_done), 32'(e.fdone));
                    check("line_len_err", 32'(line_len_err), 32'(e.lerr));
                    check("frame_len_err", 32'(frame_len_err), 32'(e.ferr));
                    if (e.fdone) check("frame_crc_at_done", 32'(frame_crc), 32'(e.crc));
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        lcd_vsync_n = 1'b1; lcd_hsync_n = 1'b1; lcd_de = 1'b0;
        lcd_r = 8'h0; lcd_g = 8'h0; lcd_b = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        model_reset();
        reset = 1'b1;
        model_on = 1'b1;
        repeat (3) tick(1, 1, 0, 8'h0, 8'h0, 8'h0);

        // Clean frame with deterministic colours
        send_frame('{8, 8, 8, 8}, 0);
        // Long line 1
        send_frame('{8, 10, 8, 8}, 0);
        // Short line 2, then early VSync, then a clean frame
        send_frame('{8, 8, 5}, 0);
        send_frame('{8, 8, 8, 8}, 0);

        // VSync assert in the same cycle as DE rise
        tick(1, 1, 0, 8'h0, 8'h0, 8'h0);
        tick(0, 1, 1, 8'hEE, 8'hEE, 8'hEE);
        for (int i = 0; i < H; i++) tick(1, 1, 1, 8'(i), 8'h0, 8'h5A);
        tick(1, 1, 0, 8'h0, 8'h0, 8'h0);
        for (int i = 1; i < V; i++) send_line(H, i, 0);

        // Extra line after a complete frame, then DE while idle
        send_frame('{8, 8, 8, 8, 8}, 1);
        send_line(8, 5, 1);

        // Reset mid-frame, right after pixel (3,1) is driven
        vsync_pulse();
        send_line(8, 0, 0);
        tick(1, 0, 0, 8'h0, 8'h0, 8'h0);
        tick(1, 1, 0, 8'h0, 8'h0, 8'h0);
        for (int i = 0; i < 4; i++) tick(1, 1, 1, 8'(i), 8'h1, 8'h5A);
        reset = 1'b0;
        model_on = 1'b0;
        model_reset();
        #1;
        check_outputs_zero("mid_frame_reset");
        repeat (2) tick(1, 1, 1, 8'h0, 8'h0, 8'h0);
        reset = 1'b1;
        model_on = 1'b1;
        m_prev_vs = 1'b1;
        send_line(8, 0, 1);
        send_line(8, 1, 1);
        send_frame('{8, 8, 8, 8}, 0);

        // CRC on an all-zero frame, then an errored frame that must not disturb it
        send_frame('{8, 8, 8, 8}, 2);
        send_frame('{8, 3}, 1);

        // Random frames
        for (int f = 0; f < 6; f++) begin
            int lens[$];
            int nl;
            nl = $urandom_range(3, 5);
            for (int l = 0; l < nl; l++) begin
                case ($urandom_range(0, 4))
                    0:       lens.push_back(7);
                    1:       lens.push_back(9);
                    default: lens.push_back(8);
                endcase
            end
            send_frame(lens, 1);
        end
        send_frame('{8, 8, 8, 8}, 1);

        repeat (6) tick(1, 1, 0, 8'h0, 8'h0, 8'h0);
        check("scoreboard_drained", exp_q.size(), 0);
        check("frame_crc_final", 32'(frame_crc), 32'(m_frame_crc));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_rgb_capture.md
Name: lcd_rgb_capture

Overview:
- Receive side of the parallel-RGB LCD bus (DE mode) that our LCD interface drives: Dclk, active-low HSync/VSync, DE, 8:8:8 RGB.
- Samples the bus on the pixel clock and rebuilds pixel coordinates and frame/line framing.
- Emits a registered pixel stream with x/y and flags malformed lines and frames.
- Used as an in-fabric loopback monitor for the LCD path and as the front end of the future frame-capture buffer.

Parameters:
- H_ACTIVE, 480, active pixels per line (x range 0..H_ACTIVE-1, fits 10 bits).
- V_ACTIVE, 272, active lines per frame (y range 0..V_ACTIVE-1, fits 9 bits).

Ports:
- clk  in  1  pixel clock (Dclk domain); all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- lcd_hsync_n  in  1  line sync, active low.
- lcd_vsync_n  in  1  frame sync, active low.
- lcd_de  in  1  data enable, high on active pixels.
- lcd_r, lcd_g, lcd_b  in  8 each  pixel colour.
- pix_valid  out  1  one-cycle qualifier for pix_* outputs.
- pix_x  out  10  column of the current pixel.
- pix_y  out  9  row of the current pixel.
- pix_r, pix_g, pix_b  out  8 each  captured colour.
- frame_start  out  1  pulse on the first valid pixel of a frame (coincides with pix_valid at x=0, y=0).
- frame_done  out  1  pulse when line V_ACTIVE-1 completes with correct length.
- line_len_err  out  1  pulse: a line was not exactly H_ACTIVE pixels.
- frame_len_err  out  1  pulse: VSync arrived before V_ACTIVE lines completed, or an extra line arrived.
- frame_crc  out  16  CRC of the last completed frame (see Optional Feature).

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE. Reset mid-frame discards the partial frame; capture resumes only after the next VSync assertion.
- Stage 1 registers all bus inputs. Stage 2 holds the registered outputs. A pixel on the bus at edge N appears on pix_* with pix_valid at edge N+2. Error and done pulses share this 2-cycle alignment.
- VSync assert is the registered lcd_vsync_n falling edge (1 to 0). HSync is informational only; line boundaries come from DE edges.
- IDLE: ignore DE. On VSync assert go to WAIT_LINE with y=0.
- WAIT_LINE:
  - DE rise: go to ACTIVE, x=0, emit the pixel.
  - If y==V_ACTIVE on DE rise: drop the line, pulse frame_len_err once, go to IDLE.
- ACTIVE:
  - Each DE-high cycle with x<H_ACTIVE emits a pixel, then x++.
  - DE high at x==H_ACTIVE: drop the pixel. line_len_err pulses once per line, on the first overflow cycle.
  - DE fall: if x!=H_ACTIVE (short line), pulse line_len_err. Then y++ and go to WAIT_LINE.
  - DE fall with y==V_ACTIVE-1 and a correct-length line: pulse frame_done.
- VSync assert in WAIT_LINE or ACTIVE with y<V_ACTIVE, and no frame_done yet for this frame: pulse frame_len_err, restart at y=0 in WAIT_LINE.
- Simultaneous VSync assert and DE high: VSync wins; the pixel is dropped and not counted.
- x saturates at H_ACTIVE; y saturates at V_ACTIVE. No wrap-around.
- frame_done and frame_len_err never pulse in the same cycle.

Optional Feature:
- Macro: LCD_CAPTURE_CRC_EN.
- Defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection) runs over each emitted pixel, bytes in order R, G, B (24 bits per pixel per cycle).
  - The CRC resets at VSync assert.
  - On frame_done the result loads into frame_crc, which holds until the next frame_done or reset.
- Not defined: frame_crc is constant 0 and no CRC logic is instantiated.

Decomposition:
- Package lcd_rx_pkg:
  - state enum: IDLE, WAIT_LINE, ACTIVE.
  - default H_ACTIVE/V_ACTIVE constants.
  - CRC_POLY=16'h1021, CRC_INIT=16'hFFFF.
  - pixel struct {r,g,b}.
- One sub-module, pixel_crc16: 24-bit-per-cycle combinational CRC step plus its register, instantiated only under LCD_CAPTURE_CRC_EN.

Test Plan (H_ACTIVE=8, V_ACTIVE=4):
- Clean frame: VSync pulse, 4 lines of 8 DE cycles with R=x, G=y, B=0x5A. Expect 32 pix_valid, coordinates (0,0)..(7,3) each 2 cycles after input, frame_start with (0,0), frame_done after (7,3), no errors.
- Long line: line 1 DE high 10 cycles. Expect 8 pixels, 1 line_len_err pulse, y continues to 2; remaining lines normal.
- Short line plus early VSync: line 2 DE high 5 cycles. Expect line_len_err at DE fall. Then VSync after line 2: frame_len_err, next DE rise yields (0,0).
- Simultaneous events: VSync assert in the same cycle as DE rise. Expect no pix_valid for that cycle; the next DE-high cycle emits (0,0) of the new frame.
- Reset mid-frame: assert reset at pixel (3,1). Expect all outputs 0 immediately. Later DE activity with no VSync gives no pix_valid; after VSync, normal capture resumes.
- CRC (LCD_CAPTURE_CRC_EN): clean frame with all pixels 0x000000. frame_crc must equal the golden model value at frame_done and hold through a following errored frame.
